gear_shift_ctrl: RTL
====================

Name: gear_shift_ctrl

Overview:
Parametrised paddle-shift controller for the gearbox actuator, succeeding the fixed-function shifter test block. Synchronises and debounces the up/down/neutral buttons, tracks the current gear, and fires timed actuator pulses (upOut/downOut) followed by a mechanical lockout. Provides gear number, one-hot gear LEDs, a neutral LED and a reject strobe for the dash.

Parameters:
NUM_GEARS, 5, highest gear; gears are 1..NUM_GEARS, 0 = neutral.
DEBOUNCE_CYCLES, 50000, cycles a synchronised button level must be stable before it is accepted (>=1).
UP_PULSE_CYCLES, 2000000, upOut pulse width for a full upshift (>=1).
DOWN_PULSE_CYCLES, 2000000, downOut pulse width for a full downshift (>=1).
NEUTRAL_PULSE_CYCLES, 800000, half-shift pulse width used to find neutral (>=1).
LOCKOUT_CYCLES, 1000000, dead time after any pulse before the next shift is accepted (>=0).

Ports:
clk  input  1  system clock
nReset  input  1  asynchronous active-low reset
upBut  input  1  raw up paddle, active high, asynchronous
downBut  input  1  raw down paddle, active high, asynchronous
neutralBut  input  1  raw neutral button, active high, asynchronous
upOut  output  1  up actuator drive, registered
downOut  output  1  down actuator drive, registered
gear  output  $clog2(NUM_GEARS+1)  current gear, 0 = neutral
gearLed  output  NUM_GEARS  one-hot, bit k-1 set in gear k; all zero in neutral
neutralLed  output  1  high when gear == 0
busy  output  1  high in any state other than IDLE
reject  output  1  single-cycle strobe when an accepted press is refused

Behaviour:
- Reset (nReset low, asynchronous): upOut=0, downOut=0, gear=0, gearLed=0, neutralLed=1, busy=0, reject=0, FSM=IDLE, sync/debounce state=0, counters=0. Takes effect immediately, including mid-pulse.
- Input path per button: 2-flop synchroniser; debounce counter increments while synced level != debounced level, clears otherwise; debounced level flips when count reaches DEBOUNCE_CYCLES. Press event = debounced rising edge (one cycle).
- Latency: raw held high from the first sampling edge E0 -> event at edge E0+DEBOUNCE_CYCLES+2 -> upOut/downOut high from edge E0+DEBOUNCE_CYCLES+3.
- Glitches shorter than DEBOUNCE_CYCLES cycles after synchronisation produce no event. Releases produce no action.
- Simultaneous events in one cycle: neutral wins over up/down; up+down together (no neutral) -> both discarded, reject=1.
- FSM states: IDLE, PULSE_UP, PULSE_DOWN, LOCKOUT.
- IDLE, up event: gear 0 -> 2; gear k, 1<=k<NUM_GEARS -> k+1; PULSE_UP for UP_PULSE_CYCLES. gear==NUM_GEARS -> reject, stay IDLE.
- IDLE, down event: gear 0 -> 1; gear k>1 -> k-1; PULSE_DOWN for DOWN_PULSE_CYCLES. gear==1 -> reject.
- IDLE, neutral event: gear 1 -> PULSE_UP for NEUTRAL_PULSE_CYCLES; gear 2 -> PULSE_DOWN for NEUTRAL_PULSE_CYCLES; gear becomes 0. Any other gear (incl. 0) -> reject.
- gear, gearLed, neutralLed update on the same edge the pulse output rises.
- PULSE_x: output high for exactly the selected width, then LOCKOUT. LOCKOUT: both outputs 0 for LOCKOUT_CYCLES (LOCKOUT_CYCLES=0 -> straight to IDLE), then IDLE.
- upOut and downOut never high together. busy = (FSM != IDLE).
- Events arriving while busy are discarded (not queued, no reject). A button still held when IDLE resumes does not re-fire; a new press is required.
- Pulse/lockout counters sized $clog2(max width + 1); no wrap possible.

Test Plan:
Parameters for all: NUM_GEARS=5, DEBOUNCE_CYCLES=4, UP_PULSE=8, DOWN_PULSE=6, NEUTRAL_PULSE=3, LOCKOUT=5.
1. Reset, hold upBut 20 cycles -> upOut high from edge 7 for exactly 8 cycles, gear 0->2, gearLed=00010, neutralLed=0, busy high 13 cycles.
2. upBut high 3 cycles then low -> no upOut, gear unchanged, busy stays 0.
3. From gear 2, four separate up presses -> gear 3,4,5 then 5th press gives reject for 1 cycle, no upOut, gear stays 5; down at gear 1 likewise rejected.
4. Second up press during PULSE_UP and during LOCKOUT -> discarded, exactly one pulse observed, gear +1 only; up+down on the same cycle in IDLE -> reject, no pulse.
5. Neutral in gear 1 -> upOut 3 cycles, gear 0, neutralLed=1; neutral in gear 2 -> downOut 3 cycles, gear 0; neutral in gear 3 -> reject.
6. Drop nReset mid-PULSE_UP between clock edges -> upOut=0 and gear=0 immediately; after release a fresh press is needed to shift.

Source files
------------

// File: rtl/gear_shift_ctrl.sv
// ---------------------------------------------------------------------------
// gear_shift_ctrl
// Paddle-shift controller for the gearbox actuator. Each raw button is
// synchronised and debounced; a debounced rising edge is a one-cycle press
// event. The FSM tracks the current gear, fires one timed actuator pulse per
// accepted shift, then holds a mechanical lockout before accepting another
// shift.
//
// Ports
//   clk         system clock
//   nReset      asynchronous active-low reset
//   upBut       raw up paddle, active high, asynchronous
//   downBut     raw down paddle, active high, asynchronous
//   neutralBut  raw neutral button, active high, asynchronous
//   upOut       up actuator drive (registered)
//   downOut     down actuator drive (registered)
//   gear        current gear, 0 = neutral
//   gearLed     one-hot gear indicator, bit k-1 set in gear k, zero in neutral
//   neutralLed  high while gear == 0
//   busy        high whenever the FSM is not IDLE
//   reject      one-cycle strobe when an accepted press is refused
// ---------------------------------------------------------------------------
module gear_shift_ctrl #(
  parameter int NUM_GEARS            = 5,
  parameter int DEBOUNCE_CYCLES      = 50000,
  parameter int UP_PULSE_CYCLES      = 2000000,
  parameter int DOWN_PULSE_CYCLES    = 2000000,
  parameter int NEUTRAL_PULSE_CYCLES = 800000,
  parameter int LOCKOUT_CYCLES       = 1000000
) (
  input  logic                             clk,
  input  logic                             nReset,
  input  logic                             upBut,
  input  logic                             downBut,
  input  logic                             neutralBut,
  output logic                             upOut,
  output logic                             downOut,
  output logic [$clog2(NUM_GEARS+1)-1:0]   gear,
  output logic [NUM_GEARS-1:0]             gearLed,
  output logic                             neutralLed,
  output logic                             busy,
  output logic                             reject
);

  localparam int GW     = $clog2(NUM_GEARS + 1);
  localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MAX_AB = (UP_PULSE_CYCLES > DOWN_PULSE_CYCLES) ? UP_PULSE_CYCLES : DOWN_PULSE_CYCLES;
  localparam int MAX_CD = (NEUTRAL_PULSE_CYCLES > LOCKOUT_CYCLES) ? NEUTRAL_PULSE_CYCLES : LOCKOUT_CYCLES;
  localparam int MAX_W  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_W + 1);

  // Counters are loaded with width-1 and run down to zero, so a state lasts
  // exactly "width" cycles.
  localparam logic [CW-1:0] UP_LOAD   = CW'(UP_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] DOWN_LOAD = CW'(DOWN_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] NEU_LOAD  = CW'(NEUTRAL_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LOAD = CW'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES);
  localparam logic [GW-1:0] TOP_GEAR  = GW'(NUM_GEARS);
  localparam logic [GW-1:0] GEAR_0    = GW'(0);
  localparam logic [GW-1:0] GEAR_1    = GW'(1);
  localparam logic [GW-1:0] GEAR_2    = GW'(2);

  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_NEU  = 2;

  typedef enum logic [1:0] {IDLE, PULSE_UP, PULSE_DOWN, LOCKOUT} state_t;

  logic [2:0]     raw_s;
  logic [2:0]     sync1_r;
  logic [2:0]     sync2_r;
  logic [2:0]     deb_r;
  logic [2:0]     press_r;
  logic [DW-1:0]  deb_cnt_r [3];

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [GW-1:0]  gear_r, gear_s;
  logic           reject_s;

  logic           up_out_r, down_out_r, neutral_led_r, busy_r, reject_r;
  logic [NUM_GEARS-1:0] gear_led_r;

  function automatic logic [NUM_GEARS-1:0] led_of(input logic [GW-1:0] g);
    logic [NUM_GEARS-1:0] v;
    v = '0;
    for (int k = 1; k <= NUM_GEARS; k++) begin
      v[k-1] = (g == GW'(k));
    end
    return v;
  endfunction

  assign raw_s = {neutralBut, downBut, upBut};

  // Synchroniser, debounce counters and one-cycle press events per button.
  // The debounced level flips on the edge at which the counter already holds
  // DEBOUNCE_CYCLES; the press event is registered on that same edge.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      deb_r   <= 3'b000;
      press_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (deb_cnt_r[i] == DEB_MAX) begin
            deb_r[i]     <= sync2_r[i];
            deb_cnt_r[i] <= '0;
            press_r[i]   <= sync2_r[i];
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
            press_r[i]   <= 1'b0;
          end
        end else begin
          deb_cnt_r[i] <= '0;
          press_r[i]   <= 1'b0;
        end
      end
    end
  end

  // Next-state, gear and reject decode. Press events outside IDLE are
  // simply dropped because only the IDLE branch looks at them.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    gear_s   = gear_r;
    reject_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (press_r[BTN_NEU]) begin
          if (gear_r == GEAR_1) begin
            state_s = PULSE_UP;
            cnt_s   = NEU_LOAD;
            gear_s  = GEAR_0;
          end else if (gear_r == GEAR_2) begin
            state_s = PULSE_DOWN;
            cnt_s   = NEU_LOAD;
            gear_s  = GEAR_0;
          end else begin
            reject_s = 1'b1;
          end
        end else if (press_r[BTN_UP] && press_r[BTN_DOWN]) begin
          reject_s = 1'b1;
        end else if (press_r[BTN_UP]) begin
          if (gear_r == TOP_GEAR) begin
            reject_s = 1'b1;
          end else begin
            state_s = PULSE_UP;
            cnt_s   = UP_LOAD;
            // From neutral the lever goes up past neutral into second gear.
            gear_s  = (gear_r == GEAR_0) ? GEAR_2 : gear_r + GW'(1);
          end
        end else if (press_r[BTN_DOWN]) begin
          if (gear_r == GEAR_1) begin
            reject_s = 1'b1;
          end else begin
            state_s = PULSE_DOWN;
            cnt_s   = DOWN_LOAD;
            gear_s  = (gear_r == GEAR_0) ? GEAR_1 : gear_r - GW'(1);
          end
        end else begin
          state_s = IDLE;
        end
      end
      PULSE_UP, PULSE_DOWN: begin
        if (cnt_r == '0) begin
          if (LOCKOUT_CYCLES == 0) begin
            state_s = IDLE;
            cnt_s   = '0;
          end else begin
            state_s = LOCKOUT;
            cnt_s   = LOCK_LOAD;
          end
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      LOCKOUT: begin
        if (cnt_r == '0) begin
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State register and registered dash/actuator outputs, all taken from the
  // next-state values so gear and the pulse change on the same edge.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      gear_r        <= GEAR_0;
      up_out_r      <= 1'b0;
      down_out_r    <= 1'b0;
      gear_led_r    <= '0;
      neutral_led_r <= 1'b1;
      busy_r        <= 1'b0;
      reject_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      gear_r        <= gear_s;
      up_out_r      <= (state_s == PULSE_UP);
      down_out_r    <= (state_s == PULSE_DOWN);
      gear_led_r    <= led_of(gear_s);
      neutral_led_r <= (gear_s == GEAR_0);
      busy_r        <= (state_s != IDLE);
      reject_r      <= reject_s;
    end
  end

  assign upOut      = up_out_r;
  assign downOut    = down_out_r;
  assign gear       = gear_r;
  assign gearLed    = gear_led_r;
  assign neutralLed = neutral_led_r;
  assign busy       = busy_r;
  assign reject     = reject_r;

endmodule
